// File: rtl/nibble_serial_tx.sv
// Parallel-in, serial-out nibble transmitter: start bit, 4 data bits LSB first,
// optional even parity, stop bit. Line idles high.
module nibble_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] D,
    input  logic       st,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [3:0] Q
);

    // Timer stays at least one bit wide so CLKS_PER_BIT=1 still elaborates.
    localparam int            TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TC = TW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [3:0]    q_q, q_d;
    logic          done_q, done_d;
    logic          tc;

    assign tc = (timer_q == TC);

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        q_d     = q_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE && !tc) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (st) begin
                    shift_d = D;
                    q_d     = D;
                    par_d   = ^D;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tc) begin
                    state_d = S_DATA;
                    idx_d   = 2'd0;
                end
            end
            S_DATA: begin
                if (tc) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tc) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tc) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= 2'd0;
            shift_q <= 4'd0;
            par_q   <= 1'b0;
            q_q     <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = par_q;
            default:  tx = 1'b1;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign Q    = q_q;

endmodule

// File: doc/nibble_serial_tx.md
# nibble_serial_tx

Parallel-in, serial-out transmitter for the 4-bit D flip-flop register datapath. It captures a nibble on a store strobe and shifts it out on one wire as a framed serial word: start bit, 4 data bits LSB first, optional even parity, then a stop bit. It is the send end of the lab's serial link. It drains words that the 4-bit register stages produce toward a matching receiver.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal range is 1 to 255.
- `PARITY_EN`, default 1: 1 inserts an even-parity bit after D3; 0 omits it.

Ports:
- `clk`  input  1: single clock; all state changes on the rising edge.
- `clr`  input  1: reset, synchronous and active-high.
- `D`  input  4: nibble to send; sampled only on an accepted `st`.
- `st`  input  1: store/start strobe; level-sampled each cycle.
- `tx`  output  1: serial line; idles high.
- `busy`  output  1: high while a frame is in progress.
- `done`  output  1: one-cycle pulse when a frame completes.
- `Q`  output  4: the last accepted nibble, held until the next accepted `st`.

## Operation
- The FSM states are IDLE, START, DATA, PARITY and STOP. `st` is accepted only when the FSM is in IDLE.
- **IDLE:** `tx` is 1 and `busy` is 0. On `st`=1, the block loads `D` into the shift register and into `Q`, computes P = ^D, and moves to START.
- **START:** `tx` is 0 for `CLKS_PER_BIT` cycles, then the FSM moves to DATA.
- **DATA:** `tx` = shift[0]. After each `CLKS_PER_BIT` cycles the register shifts right and the bit index increments. After bit index 3 completes, the FSM moves to PARITY if `PARITY_EN`=1, otherwise to STOP.
- **PARITY:** `tx` = P for `CLKS_PER_BIT` cycles, so the count of ones in D plus P is even. The FSM then moves to STOP.
- **STOP:** `tx` is 1 for `CLKS_PER_BIT` cycles, then the FSM moves to IDLE and raises `done`.
- `busy` = 1 in every state except IDLE.
- `st` is ignored while `busy`=1. `Q` and the frame in flight are unaffected.
- **Bit timer:** counts from 0 to `CLKS_PER_BIT`-1. The bit advances on terminal count, and the timer wraps to 0 on every state or bit change.
  - The timer is at least 1 bit wide.
  - With `CLKS_PER_BIT`=1 it never counts, and every bit lasts exactly 1 cycle.
- `D` changing during a frame has no effect, because only the captured copy is transmitted.

## Timing
Reset (`clr`=1 at an edge) forces the following on the next cycle:
- `tx`=1, `busy`=0, `done`=0, `Q`=4'b0000.
- The FSM is in IDLE, and the bit timer and bit index are 0.
- A frame in progress is abandoned with no `done`.
- `clr` wins over `st` in the same cycle.

Let C = `CLKS_PER_BIT`, with `st` accepted at edge 0. Edge n means the cycle following rising edge n.
- START occupies cycles 1..C, and `busy` rises in cycle 1.
- Data bit k occupies cycles (k+1)C+1 .. (k+2)C.
- PARITY, when enabled, occupies cycles 5C+1..6C.
- STOP occupies cycles 6C+1..7C with parity enabled, or 5C+1..6C without.
- In cycle 7C+1 (parity on) or 6C+1 (parity off), the FSM is in IDLE, `busy`=0 and `done`=1 for exactly one cycle.
- Frame length is 7C cycles with parity, 6C without.
- `Q` updates in cycle 1, one cycle after the accepting edge.
- **Back-to-back frames:** `st`=1 during the `done` cycle is accepted. The next START begins in the following cycle, so there is no extra idle gap; the line stays high only for the stop bit.
- `done` and `busy` are never high in the same cycle.

## Test plan
- **Reset:** assert `clr` for 2 cycles with `st`=1 and D=4'hF. Required: `tx`=1, `busy`=0, `done`=0 and `Q`=0 throughout, and no frame starts.
- **Basic frame:** C=4, parity on, D=4'b1011, 1-cycle `st`. Required serial bits on `tx`, each 4 cycles wide:
  - 0, then 1, 1, 0, 1, then parity 1, then stop 1.
  - `busy` is high over cycles 1–28, `done` is high in cycle 29 only, and `Q`=4'hB from cycle 1.
- **Strobe while busy:** during that frame, pulse `st` with D=4'h2 at cycle 10. Required: frame bits unchanged, `Q` stays 4'hB, and `tx` stays 1 after `done`.
- **Back-to-back, parity off:** C=1, `PARITY_EN`=0, D=4'h5 then D=4'hA, with the second `st` in the `done` cycle. Required `tx` sequence: 0,1,0,1,0,1 then 0,0,1,0,1,1. `done` pulses in cycles 7 and 14.
- **Reset mid-frame:** C=4, D=4'h6, assert `clr` at cycle 13. Required: `tx`=1 and `busy`=0 from cycle 14, with no `done`. A new `st` with D=4'h9 then produces a full correct frame with P=0.
- **Parity zero:** C=2, D=4'h0. Required: data bits all 0 and parity bit 0, with 14 cycles from START to `done`-1.
